// File: rtl/mem_lock_arbiter_if.sv
// Per-core memory request and lock request/response bundle for mem_lock_arbiter.
// The slave modport is the arbiter side; master is the core-cluster side.
interface mem_lock_arbiter_if #(
    parameter int C  = 8,
    parameter int NL = 16
);
    localparam int LW = $clog2(NL);

    logic [C-1:0]          rd_req;
    logic [C-1:0]          wr_req;
    logic [C-1:0][15:0]    rd_adr;
    logic [C-1:0][15:0]    wr_adr;
    logic [C-1:0][15:0]    wr_dat;
    logic [C-1:0]          mem_ac;
    logic [15:0]           mem_adr;
    logic [15:0]           mem_wdat;
    logic                  mem_we;
    logic                  mem_re;

    logic [C-1:0][LW-1:0]  lock_adr;
    logic [C-1:0]          lock_en;
    logic [C-1:0]          unlock_en;
    logic [C-1:0]          lock_ac;
    logic [NL-1:0]         lock_busy;
    logic                  lock_err;

    modport slave (
        input  rd_req, wr_req, rd_adr, wr_adr, wr_dat,
        input  lock_adr, lock_en, unlock_en,
        output mem_ac, mem_adr, mem_wdat, mem_we, mem_re,
        output lock_ac, lock_busy, lock_err
    );

    modport master (
        output rd_req, wr_req, rd_adr, wr_adr, wr_dat,
        output lock_adr, lock_en, unlock_en,
        input  mem_ac, mem_adr, mem_wdat, mem_we, mem_re,
        input  lock_ac, lock_busy, lock_err
    );
endinterface

// File: rtl/mem_lock_arbiter.sv
// Round-robin shared-memory arbiter plus an independent round-robin lock-register unit.
// Grants and lock acks are registered: requests sampled at edge N show up in cycle N+1.
module mem_lock_arbiter #(
    parameter int C  = 8,
    parameter int NL = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_lock_arbiter_if.slave bus
);
    localparam int PW = $clog2(C);
    localparam int LW = $clog2(NL);

    logic [C-1:0]          mem_ac_q,   mem_ac_d;
    logic                  mem_we_q,   mem_we_d;
    logic                  mem_re_q,   mem_re_d;
    logic [15:0]           mem_adr_q,  mem_adr_d;
    logic [15:0]           mem_wdat_q, mem_wdat_d;
    logic [PW-1:0]         mem_ptr_q,  mem_ptr_d;

    logic [C-1:0]          lock_ac_q,  lock_ac_d;
    logic [NL-1:0]         busy_q,     busy_d;
    logic [NL-1:0][PW-1:0] owner_q,    owner_d;
    logic                  lock_err_q, lock_err_d;
    logic [PW-1:0]         lock_ptr_q, lock_ptr_d;

    logic [C-1:0]          mem_elig;
    logic [C-1:0]          lock_elig;
    logic [PW:0]           mem_pick;
    logic [PW:0]           lock_pick;
    logic [PW-1:0]         mem_win;
    logic [PW-1:0]         lock_win;
    logic [LW-1:0]         elig_adr;
    logic [LW-1:0]         win_adr;

    // Returns {found, index}; scanning downward leaves the entry closest to ptr.
    function automatic logic [PW:0] rr_pick(input logic [C-1:0] elig,
                                            input logic [PW-1:0] ptr);
        logic [PW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = C - 1; i >= 0; i--) begin
            idx = ptr + PW'(i);
            if (elig[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin : mem_arb
        // A core acked this cycle still shows its held level; mask it to avoid a double grant.
        mem_elig   = (bus.rd_req | bus.wr_req) & ~mem_ac_q;
        mem_pick   = rr_pick(mem_elig, mem_ptr_q);
        mem_win    = mem_pick[PW-1:0];
        mem_ac_d   = '0;
        mem_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        mem_adr_d  = mem_adr_q;
        mem_wdat_d = mem_wdat_q;
        mem_ptr_d  = mem_ptr_q;
        if (mem_pick[PW]) begin
            mem_ac_d[mem_win] = 1'b1;
            mem_ptr_d         = mem_win + PW'(1);
            if (bus.wr_req[mem_win]) begin
                mem_we_d   = 1'b1;
                mem_adr_d  = bus.wr_adr[mem_win];
                mem_wdat_d = bus.wr_dat[mem_win];
            end else begin
                mem_re_d   = 1'b1;
                mem_adr_d  = bus.rd_adr[mem_win];
            end
        end
    end

    always_comb begin : lock_arb
        elig_adr  = '0;
        lock_elig = '0;
        // Releases are always eligible; acquires only if the lock is free or already ours.
        for (int i = 0; i < C; i++) begin
            elig_adr     = bus.lock_adr[i];
            lock_elig[i] = !lock_ac_q[i] &&
                           (bus.unlock_en[i] ||
                            (bus.lock_en[i] &&
                             (!busy_q[elig_adr] || owner_q[elig_adr] == PW'(i))));
        end
        lock_pick  = rr_pick(lock_elig, lock_ptr_q);
        lock_win   = lock_pick[PW-1:0];
        win_adr    = bus.lock_adr[lock_win];
        lock_ac_d  = '0;
        busy_d     = busy_q;
        owner_d    = owner_q;
        lock_err_d = lock_err_q;
        lock_ptr_d = lock_ptr_q;
        if (lock_pick[PW]) begin
            lock_ac_d[lock_win] = 1'b1;
            lock_ptr_d          = lock_win + PW'(1);
            if (bus.unlock_en[lock_win]) begin
                if (busy_q[win_adr] && owner_q[win_adr] == lock_win) begin
                    busy_d[win_adr] = 1'b0;
                end else begin
                    lock_err_d = 1'b1;
                end
            end else if (!busy_q[win_adr]) begin
                busy_d[win_adr]  = 1'b1;
                owner_d[win_adr] = lock_win;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_ac_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_adr_q  <= '0;
            mem_wdat_q <= '0;
            mem_ptr_q  <= '0;
            lock_ac_q  <= '0;
            busy_q     <= '0;
            owner_q    <= '0;
            lock_err_q <= 1'b0;
            lock_ptr_q <= '0;
        end else begin
            mem_ac_q   <= mem_ac_d;
            mem_we_q   <= mem_we_d;
            mem_re_q   <= mem_re_d;
            mem_adr_q  <= mem_adr_d;
            mem_wdat_q <= mem_wdat_d;
            mem_ptr_q  <= mem_ptr_d;
            lock_ac_q  <= lock_ac_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            lock_err_q <= lock_err_d;
            lock_ptr_q <= lock_ptr_d;
        end
    end

    assign bus.mem_ac    = mem_ac_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_adr   = mem_adr_q;
    assign bus.mem_wdat  = mem_wdat_q;
    assign bus.lock_ac   = lock_ac_q;
    assign bus.lock_busy = busy_q;
    assign bus.lock_err  = lock_err_q;
endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Bench for mem_lock_arbiter: a cycle table for memory arbitration plus hand sequences
// for round-robin fairness, reset, read/write ordering and the lock unit.
module tb_mem_lock_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_lock_arbiter_if #(.C(8), .NL(16)) bus ();
    mem_lock_arbiter #(.C(8), .NL(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [7:0]  mac;
        logic        we;
        logic        re;
        logic [15:0] adr;
        logic [15:0] wdat;
        logic [7:0]  lac;
        logic [15:0] busy;
        logic        err;
    } exp_t;

    typedef struct {
        logic [7:0]  rd;
        logic [7:0]  wr;
        logic [7:0]  mac;
        logic        we;
        logic        re;
        logic [15:0] adr;
        logic [15:0] wdat;
    } mvec_t;

    exp_t  e;
    exp_t  sbq[$];
    mvec_t tbl[15];
    int    nvec = 0;
    int    nmis = 0;
    int    cyc  = 0;
    int    cnt[8];
    string tag;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s/%s cycle %0d: got %h, want %h", tag, nm, cyc, act, exp);
        end
    endtask

    // Queue the expectation for the inputs now applied, clock them in, compare the result.
    task automatic tick();
        exp_t x;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        x = sbq.pop_front();
        chk("mem_ac",    {8'h00, bus.mem_ac},   {8'h00, x.mac});
        chk("mem_we",    {15'h0, bus.mem_we},   {15'h0, x.we});
        chk("mem_re",    {15'h0, bus.mem_re},   {15'h0, x.re});
        chk("mem_adr",   bus.mem_adr,           x.adr);
        chk("mem_wdat",  bus.mem_wdat,          x.wdat);
        chk("lock_ac",   {8'h00, bus.lock_ac},  {8'h00, x.lac});
        chk("lock_busy", bus.lock_busy,         x.busy);
        chk("lock_err",  {15'h0, bus.lock_err}, {15'h0, x.err});
    endtask

    task automatic set_mexp(input logic [7:0] ac, input logic we, input logic re,
                            input logic [15:0] adr, input logic [15:0] wdat);
        e.mac = ac; e.we = we; e.re = re; e.adr = adr; e.wdat = wdat;
    endtask

    task automatic set_lexp(input logic [7:0] ac, input logic [15:0] busy, input logic err);
        e.lac = ac; e.busy = busy; e.err = err;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_mexp(8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_lexp(8'h00, 16'h0000, 1'b0);
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_addr();
        for (int i = 0; i < 8; i++) begin
            bus.wr_adr[i] = 16'h0100 + 16'(i);
            bus.rd_adr[i] = 16'h0200 + 16'(i);
            bus.wr_dat[i] = 16'hA000 + 16'(i);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.rd_req    = '0;
        bus.wr_req    = '0;
        bus.lock_adr  = '0;
        bus.lock_en   = '0;
        bus.unlock_en = '0;
        set_addr();

        tbl[0]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{8'h00, 8'h08, 8'h08, 1'b1, 1'b0, 16'h0103, 16'hA003};
        tbl[2]  = '{8'h00, 8'h08, 8'h00, 1'b0, 1'b0, 16'h0103, 16'hA003};
        tbl[3]  = '{8'h00, 8'h08, 8'h08, 1'b1, 1'b0, 16'h0103, 16'hA003};
        tbl[4]  = '{8'h01, 8'h00, 8'h01, 1'b0, 1'b1, 16'h0200, 16'hA003};
        tbl[5]  = '{8'h81, 8'h00, 8'h80, 1'b0, 1'b1, 16'h0207, 16'hA003};
        tbl[6]  = '{8'h81, 8'h00, 8'h01, 1'b0, 1'b1, 16'h0200, 16'hA003};
        tbl[7]  = '{8'h81, 8'h00, 8'h80, 1'b0, 1'b1, 16'h0207, 16'hA003};
        tbl[8]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0207, 16'hA003};
        tbl[9]  = '{8'h22, 8'h20, 8'h02, 1'b0, 1'b1, 16'h0201, 16'hA003};
        tbl[10] = '{8'h22, 8'h20, 8'h20, 1'b1, 1'b0, 16'h0105, 16'hA005};
        tbl[11] = '{8'h22, 8'h00, 8'h02, 1'b0, 1'b1, 16'h0201, 16'hA005};
        tbl[12] = '{8'h20, 8'h00, 8'h20, 1'b0, 1'b1, 16'h0205, 16'hA005};
        tbl[13] = '{8'hFF, 8'hFF, 8'h40, 1'b1, 1'b0, 16'h0106, 16'hA006};
        tbl[14] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0106, 16'hA006};

        tag = "reset";
        do_reset();

        tag = "table";
        for (int i = 0; i < 15; i++) begin
            bus.rd_req = tbl[i].rd;
            bus.wr_req = tbl[i].wr;
            set_mexp(tbl[i].mac, tbl[i].we, tbl[i].re, tbl[i].adr, tbl[i].wdat);
            set_lexp(8'h00, 16'h0000, 1'b0);
            tick();
        end
        bus.rd_req = '0;
        bus.wr_req = '0;

        // All eight cores writing continuously, wr_adr = core index.
        tag = "rr8";
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.wr_adr[i] = 16'(i);
            cnt[i] = 0;
        end
        bus.wr_req = 8'hFF;
        for (int n = 0; n < 24; n++) begin
            set_mexp(8'(1 << (n % 8)), 1'b1, 1'b0, 16'(n % 8), 16'hA000 + 16'(n % 8));
            tick();
            for (int c = 0; c < 8; c++) if (bus.mem_ac[c]) cnt[c]++;
        end
        for (int c = 0; c < 8; c++) chk("grants", 16'(cnt[c]), 16'd3);

        // One-cycle reset while all keep requesting, then reset with requests withdrawn.
        tag = "rst_mid";
        do_reset();
        set_mexp(8'h01, 1'b1, 1'b0, 16'h0000, 16'hA000);
        tick();
        set_mexp(8'h02, 1'b1, 1'b0, 16'h0001, 16'hA001);
        tick();
        bus.wr_req = '0;
        do_reset();
        tick();

        // Core 3 with read and write pending: write first, read two cycles later.
        tag = "rdwr";
        set_addr();
        bus.wr_adr[3] = 16'h0010;
        bus.rd_adr[3] = 16'h0020;
        bus.rd_req = 8'h08;
        bus.wr_req = 8'h08;
        set_mexp(8'h08, 1'b1, 1'b0, 16'h0010, 16'hA003);
        tick();
        bus.wr_req = '0;
        set_mexp(8'h00, 1'b0, 1'b0, 16'h0010, 16'hA003);
        tick();
        set_mexp(8'h08, 1'b0, 1'b1, 16'h0020, 16'hA003);
        tick();
        bus.rd_req = '0;
        set_mexp(8'h00, 1'b0, 1'b0, 16'h0020, 16'hA003);
        tick();

        // Cores 1 and 5 contend for lock 7.
        tag = "lock7";
        do_reset();
        bus.lock_adr[1] = 4'd7;
        bus.lock_adr[5] = 4'd7;
        bus.lock_en = 8'h22;
        set_lexp(8'h02, 16'h0080, 1'b0); tick();
        bus.lock_en = 8'h20;
        set_lexp(8'h00, 16'h0080, 1'b0); tick();
        bus.unlock_en = 8'h02;
        set_lexp(8'h02, 16'h0000, 1'b0); tick();
        bus.unlock_en = 8'h00;
        set_lexp(8'h20, 16'h0080, 1'b0); tick();
        bus.lock_en = 8'h00;
        set_lexp(8'h00, 16'h0080, 1'b0); tick();
        tag = "reacquire";
        bus.lock_en = 8'h20;
        set_lexp(8'h20, 16'h0080, 1'b0); tick();
        bus.lock_en = 8'h00;
        tag = "nonowner";
        bus.lock_adr[3] = 4'd7;
        bus.unlock_en = 8'h08;
        set_lexp(8'h08, 16'h0080, 1'b1); tick();
        tag = "both_en";
        bus.lock_en   = 8'h20;
        bus.unlock_en = 8'h20;
        set_lexp(8'h20, 16'h0000, 1'b1); tick();
        bus.lock_en   = 8'h00;
        bus.unlock_en = 8'h00;
        set_lexp(8'h00, 16'h0000, 1'b1); tick();

        // Release of a free lock after reset; lock_err must stay set.
        tag = "freerel";
        do_reset();
        bus.lock_adr[2] = 4'd4;
        bus.unlock_en = 8'h04;
        set_lexp(8'h04, 16'h0000, 1'b1); tick();
        bus.unlock_en = 8'h00;
        set_lexp(8'h00, 16'h0000, 1'b1); tick();
        set_lexp(8'h00, 16'h0000, 1'b1); tick();

        // Three cores acquiring different locks; lock pointer is 3 here.
        tag = "lock_rr";
        bus.lock_adr[0] = 4'd1;
        bus.lock_adr[2] = 4'd2;
        bus.lock_adr[6] = 4'd3;
        bus.lock_en = 8'h45;
        set_lexp(8'h40, 16'h0008, 1'b1); tick();
        bus.lock_en = 8'h05;
        set_lexp(8'h01, 16'h000A, 1'b1); tick();
        bus.lock_en = 8'h04;
        set_lexp(8'h04, 16'h000E, 1'b1); tick();
        bus.lock_en = 8'h00;
        set_lexp(8'h00, 16'h000E, 1'b1); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/mem_lock_arbiter.md
MEM_LOCK_ARBITER -- requirements
Module: mem_lock_arbiter

Interface
REQ-001 Parameter C, default 8, number of requesting cores; fixed at 8 for this revision.
REQ-002 Parameter NL, default 16, number of lock registers, addressed by a 4-bit lock address.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 rd_req  input  C  per-core read request; level, held until that core's mem_ac.
REQ-006 wr_req  input  C  per-core write request; level, held until that core's mem_ac.
REQ-007 rd_adr  input  C x 16  per-core read address.
REQ-008 wr_adr  input  C x 16  per-core write address.
REQ-009 wr_dat  input  C x 16  per-core write data.
REQ-010 mem_ac  output  C  one-hot grant pulse, 1 cycle, to the served core.
REQ-011 mem_adr  output  16  address to shared main memory.
REQ-012 mem_wdat  output  16  write data to shared main memory.
REQ-013 mem_we  output  1  memory write strobe.
REQ-014 mem_re  output  1  memory read strobe.
REQ-015 lock_adr  input  C x 4  per-core lock address.
REQ-016 lock_en  input  C  per-core acquire request; level, held until lock_ac.
REQ-017 unlock_en  input  C  per-core release request; level, held until lock_ac.
REQ-018 lock_ac  output  C  one-hot lock/unlock acknowledge pulse, 1 cycle.
REQ-019 lock_busy  output  NL  current held state of each lock.
REQ-020 lock_err  output  1  sticky flag, set on an unlock by a non-owner.

Function
REQ-021 Memory arbitration SHALL be round-robin over cores using a 3-bit pointer; search starts at pointer, wraps 7->0.
REQ-022 Each cycle, at most one core SHALL be granted; grant computed from inputs sampled at posedge N, outputs registered and valid in cycle N+1.
REQ-023 In the grant cycle: mem_ac bit of winner =1; mem_adr/mem_wdat/mem_we/mem_re driven from that core's registered request.
REQ-024 A core asserting both rd_req and wr_req SHALL be served write first; read served on a later grant.
REQ-025 After a grant to core k the pointer SHALL become (k+1) mod 8; with no requests the pointer holds.
REQ-026 A core SHALL NOT be granted in two consecutive cycles (its request is masked the cycle its mem_ac is high), preventing re-grant on a held level.
REQ-027 With all 8 cores requesting continuously, each SHALL receive exactly one grant in every 8 consecutive grants.
REQ-028 Lock unit: per lock a busy bit and 3-bit owner; one lock operation (acquire or release) processed per cycle, chosen round-robin with its own 3-bit pointer, independent of memory arbitration.
REQ-029 Acquire of a free lock SHALL set busy, record owner, pulse lock_ac next cycle.
REQ-030 Acquire of a lock held by another core SHALL be not eligible (no ack); the core keeps requesting; the pointer skips it.
REQ-031 Acquire of a lock already owned by the requester SHALL ack with no state change.
REQ-032 Release by the owner SHALL clear busy and ack; release by a non-owner or of a free lock SHALL ack, change no state, set lock_err.
REQ-033 A core asserting lock_en and unlock_en together SHALL be treated as release only.
REQ-034 Release and competing acquire of the same lock SHALL take separate cycles; acquire is granted no earlier than the cycle after the release is processed.
REQ-035 lock_busy SHALL reflect registered state (updated the cycle the op is processed).

Reset
REQ-036 While reset_n=0 at posedge: mem_ac=0, lock_ac=0, mem_we=0, mem_re=0, mem_adr=0, mem_wdat=0, both pointers=0, all busy=0, owners=0, lock_err=0.
REQ-037 Reset mid-operation SHALL abort any pending grant; no mem_ac/lock_ac pulse in the cycle after reset deasserts unless a request is sampled then.

Verification
REQ-038 All 8 cores wr_req held, wr_adr=i -> mem_ac order cores 0..7 repeating, mem_we=1, mem_adr=granted index each grant.
REQ-039 Core 3 rd_req+wr_req, wr_adr=0x10, rd_adr=0x20 -> grant 1 mem_we=1 adr 0x10, grant 2 (>=2 cycles later) mem_re=1 adr 0x20.
REQ-040 Cores 1 and 5 lock_en adr 7 same cycle -> core 1 ack, lock_busy[7]=1; core 5 acked only after core 1 unlock_en acked.
REQ-041 Core 2 unlock_en adr 4 while lock 4 free -> lock_ac[2] pulse, lock_busy unchanged, lock_err=1 and stays 1.
REQ-042 reset_n=0 for one cycle during continuous requests -> all outputs 0 next cycle, pointer restart: first grant core 0.
